alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU, successor to the 3-bit-opcode single-cycle ALU in the execute stage. Handles WIDTH-bit operands, a 4-bit opcode adding XOR, signed compare, shifts, and iterative multiply/divide. Single-cycle ops are accepted back-to-back. Multiply/divide ops stall the issuer through a valid/ready handshake. The result is registered and flagged with a one-cycle valid pulse.

## Interface
- WIDTH, 32: operand and result width, at least 4.
- iClk  in  1  clock; all state changes on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iValid  in  1  operation request.
- oReady  out  1  block can accept; combinational, high iff state IDLE.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- iF  in  4  opcode.
- oValid  out  1  one-cycle pulse: oY holds a new result.
- oY  out  WIDTH  registered result; holds until the next result.
- oZero  out  1  (oY == 0), derived from registered oY.

## Operation
- Accept = iValid && oReady at a rising edge. iA, iB, iF are sampled only at accept. Requests while oReady=0 are ignored.
- Opcodes 0000–0111 are unchanged from the previous generation, except 0011:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 A&~B; 0101 A|~B; 0110 SUB.
  - 0111 SLTU: unsigned less-than, result 1 or 0.
- New opcodes:
  - 1000 SLT: signed less-than.
  - 1001 SLL, 1010 SRL, 1011 SRA: shift amount = iB[$clog2(WIDTH)-1:0]; upper bits of iB are ignored.
  - 1100 MUL: low WIDTH bits of unsigned A*B.
  - 1101 MULHU: high WIDTH bits of unsigned A*B.
  - 1110 DIVU: unsigned quotient.
  - 1111 REMU: unsigned remainder.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - Divide by zero: DIVU returns all ones, REMU returns A, same latency as a normal divide.
- Opcodes 0000–1011 are single-cycle. At the accept edge, oY is loaded and oValid is set for the next cycle. State stays IDLE, so throughput is 1 op/cycle.
- Opcodes 1100–1111 are iterative, with state machine IDLE → BUSY → IDLE:
  - Accept: latch operands, counter = 0, go to BUSY.
  - BUSY, counter < WIDTH: one shift-add (mul) or restoring-subtract (div) step per edge, counter++.
  - BUSY, counter == WIDTH: load oY, pulse oValid, go to IDLE.
- oValid has no backpressure. The consumer must take oY in the pulse cycle.

## Timing
- Reset values: state IDLE, oY = 0, oZero = 1, oValid = 0, counter = 0, internal datapath registers = 0. oReady = 1 in the cycle after reset.
- Single-cycle op latency: oValid is high in the cycle after the accept edge.
- Iterative op latency: WIDTH+1 cycles.
  - oReady is low for exactly WIDTH+1 cycles after the accept edge.
  - oValid and oReady are both high in the cycle after edge WIDTH+1. A new accept is legal in that cycle.
- Reset during BUSY aborts the operation: no oValid, and oY returns to 0.
- Reset takes priority over an accept at the same edge.
- oY and oZero are unchanged during BUSY until the final edge.

## Structure
- Package alu_pkg holds:
  - enum alu_op_e (4-bit, the 16 opcodes above).
  - enum alu_state_e {IDLE, BUSY}.
  - Opcode-class helper: is_iter(op) = op[3] & op[2].
- Sub-module alu_muldiv holds the iterative datapath:
  - Parameter WIDTH.
  - Registers: accumulator, partial remainder/product, shifting operand, counter.
  - Interface: start, op[1:0], result, done.
- alu_mc holds the single-cycle logic, the FSM, the handshake and the output registers.

## Test plan
All scenarios use WIDTH=32.
- ADD 0xFFFFFFFF+1 → oY=0, oZero=1, oValid in the next cycle. Back-to-back AND/OR/XOR on 3 consecutive cycles → 3 consecutive oValid pulses with correct values.
- A=0xFFFFFFFF, B=1: SLT → 1; SLTU → 0. SUB 5−7 → 0xFFFFFFFE.
- A=0x80000000, B=0x24 (shift amount 4): SRA → 0xF8000000; SRL → 0x08000000; SLL of A=1 → 0x10.
- A=0x10000, B=0x10000: MUL → 0, oZero=1; MULHU → 1. oReady is low for exactly 33 cycles and oValid fires 33 cycles after accept. iValid held high throughout is ignored.
- DIVU 100/7 → 14, REMU → 2. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5.
- iRst asserted 10 cycles into a DIVU → no oValid; next cycle oReady=1, oY=0, oZero=1. A following ADD 2+3 → 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_ANDN  = 4'b0100,
    OP_ORN   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLTU  = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLL   = 4'b1001,
    OP_SRL   = 4'b1010,
    OP_SRA   = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  // Multiply/divide family occupies the top quarter of the opcode space.
  function automatic logic is_iter(input alu_op_e op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // acc: high product / partial remainder; mq: low product / quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH-1:0] diff_c;
  logic             fits_c;

  always_comb begin
    acc_d  = acc_q;
    mq_d   = mq_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    busy_d = busy_q;

    sum_c     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    shifted_c = {acc_q, mq_q[WIDTH-1]};
    fits_c    = shifted_c >= {1'b0, opnd_q};
    // True difference is below the divisor, so the low WIDTH bits are exact.
    diff_c    = shifted_c[WIDTH-1:0] - opnd_q;

    if (start) begin
      acc_d  = '0;
      mq_d   = a;
      opnd_d = b;
      cnt_d  = '0;
      op_d   = op;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q < CW'(WIDTH)) begin
        if (op_q[1]) begin
          acc_d = fits_c ? diff_c : shifted_c[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], fits_c};
        end else begin
          acc_d = sum_c[WIDTH:1];
          mq_d  = {sum_c[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      mq_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mq_q   <= mq_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      busy_q <= busy_d;
    end
  end

  assign result = op_q[0] ? acc_q : mq_q;
  assign done   = busy_q && (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus iterative mul/div behind a ready handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [3:0]       iF,
  output logic             oValid,
  output logic [WIDTH-1:0] oY,
  output logic             oZero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;

  alu_op_e          op_c;
  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] single_y_c;
  logic             start_c;
  logic [WIDTH-1:0] md_result;
  logic             md_done;

  assign op_c    = alu_op_e'(iF);
  assign shamt_c = iB[SHW-1:0];

  always_comb begin
    single_y_c = '0;
    case (op_c)
      OP_AND:  single_y_c = iA & iB;
      OP_OR:   single_y_c = iA | iB;
      OP_ADD:  single_y_c = iA + iB;
      OP_XOR:  single_y_c = iA ^ iB;
      OP_ANDN: single_y_c = iA & ~iB;
      OP_ORN:  single_y_c = iA | ~iB;
      OP_SUB:  single_y_c = iA - iB;
      OP_SLTU: single_y_c = WIDTH'(iA < iB);
      OP_SLT:  single_y_c = WIDTH'($signed(iA) < $signed(iB));
      OP_SLL:  single_y_c = iA << shamt_c;
      OP_SRL:  single_y_c = iA >> shamt_c;
      OP_SRA:  single_y_c = WIDTH'($signed(iA) >>> shamt_c);
      default: single_y_c = '0;
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = 1'b0;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          if (is_iter(op_c)) begin
            start_c = 1'b1;
            state_d = BUSY;
          end else begin
            y_d     = single_y_c;
            valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          y_d     = md_result;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (iClk),
    .rst    (iRst),
    .start  (start_c),
    .op     (iF[1:0]),
    .a      (iA),
    .b      (iB),
    .result (md_result),
    .done   (md_done)
  );

  assign oReady = (state_q == IDLE);
  assign oValid = valid_q;
  assign oY     = y_q;
  assign oZero  = (y_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32: expected results queued on issue, checked on oValid.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         iClk = 1'b0;
  logic         iRst = 1'b1;
  logic         iValid = 1'b0;
  logic         oReady;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic [3:0]   iF = '0;
  logic         oValid;
  logic [W-1:0] oY;
  logic         oZero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  alu_mc #(.WIDTH(W)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iF     (iF),
    .oValid (oValid),
    .oY     (oY),
    .oZero  (oZero)
  );

  always #5 iClk = ~iClk;

  // Result monitor: every oValid pulse must match the oldest queued expectation.
  always @(negedge iClk) begin
    if (oValid === 1'b1) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: oY=%h with no result pending", oY);
      end else begin
        e = exp_q.pop_front();
        if (oY !== e) begin
          errors++;
          $display("FAIL result: oY=%h expected %h", oY, e);
        end
        checks++;
        if (oZero !== (e == '0)) begin
          errors++;
          $display("FAIL zero_flag: oZero=%b expected %b for %h", oZero, (e == '0), e);
        end
      end
    end
  end

  // Caller is at a negedge with oReady high; returns at the negedge after the accept edge.
  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] y);
    checks++;
    if (oReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_issue: oReady=%b expected 1 (op %b)", oReady, f);
    end
    iValid = 1'b1; iF = f; iA = a; iB = b;
    exp_q.push_back(y);
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  // Iterative op: iValid stays high with junk while busy; ready must be low exactly 33 cycles.
  task automatic send_iter(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] y);
    int n;
    send(f, a, b, y);
    iValid = 1'b1; iF = 4'b0010; iA = 32'h1111_1111; iB = 32'h2222_2222;
    n = 0;
    while (oReady !== 1'b1 && n < 100) begin
      @(negedge iClk);
      n++;
    end
    iValid = 1'b0;
    checks++;
    if (n != W + 1) begin
      errors++;
      $display("FAIL busy_cycles: oReady low %0d cycles expected %0d (op %b)", n, W + 1, f);
    end
    checks++;
    if (oValid !== 1'b1) begin
      errors++;
      $display("FAIL iter_valid_with_ready: oValid=%b expected 1 (op %b)", oValid, f);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    checks++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oY !== '0 || oZero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b y=%h zero=%b expected 1 0 0 1",
               oReady, oValid, oY, oZero);
    end
  endtask

  task automatic test_single();
    send(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);
    checks++;
    if (oValid !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: oValid=%b expected 1 one cycle after accept", oValid);
    end
    @(negedge iClk);
    send(4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE);
    send(4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1);
    send(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0);
    send(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hF000_0034);
    send(4'b0101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hF0FF_12FF);
    @(negedge iClk);
  endtask

  task automatic test_back_to_back();
    send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    send(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
    checks++;
    if (oValid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulse: oValid=%b expected 1 on second consecutive cycle", oValid);
    end
    send(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
    @(negedge iClk);
  endtask

  task automatic test_shift();
    send(4'b1011, 32'h8000_0000, 32'h24, 32'hF800_0000);
    send(4'b1010, 32'h8000_0000, 32'h24, 32'h0800_0000);
    send(4'b1001, 32'h1, 32'h24, 32'h10);
    @(negedge iClk);
  endtask

  task automatic test_muldiv();
    send_iter(4'b1100, 32'h1_0000, 32'h1_0000, 32'h0);
    send_iter(4'b1101, 32'h1_0000, 32'h1_0000, 32'h1);
    send_iter(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    send_iter(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    send_iter(4'b1110, 32'd100, 32'd7, 32'd14);
    send_iter(4'b1111, 32'd100, 32'd7, 32'd2);
    send_iter(4'b1110, 32'd5, 32'd0, 32'hFFFF_FFFF);
    send_iter(4'b1111, 32'd5, 32'd0, 32'd5);
    @(negedge iClk);
  endtask

  task automatic test_reset_abort();
    send(4'b1110, 32'd1000, 32'd3, 32'd333);
    repeat (9) @(negedge iClk);
    void'(exp_q.pop_back());
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    checks++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oY !== '0 || oZero !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: ready=%b valid=%b y=%h zero=%b expected 1 0 0 1",
               oReady, oValid, oY, oZero);
    end
    repeat (W + 4) @(negedge iClk);
    send(4'b0010, 32'd2, 32'd3, 32'd5);
    @(negedge iClk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_shift();
    test_muldiv();
    test_reset_abort();
    repeat (5) @(negedge iClk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
